// File: rtl/cmult_share_sched.sv
// Round-robin sharing of one fixed-latency complex multiplier among N requesters.
// Owner tags travel beside the multiplier; products land in credit-guarded per-requester FIFOs.

module cmult_share_lane #(
   parameter int PW         = 33,
   parameter int FIFO_DEPTH = 8
) (
   input  logic            ACLK,
   input  logic            ARESET,
   input  logic            grant,
   input  logic            push,
   input  logic [2*PW-1:0] push_p,
   input  logic            drop,
   input  logic            r_ready,
   output logic            credit_ok,
   output logic            r_valid,
   output logic [2*PW-1:0] r_p
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [2*PW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, credit;
   logic            pop, full;

   assign pop       = r_valid & r_ready;
   assign full      = (count == CW'(FIFO_DEPTH));
   assign r_valid   = (count != '0);
   assign r_p       = mem[rd_ptr];
   assign credit_ok = (credit != '0);

   always_ff @(posedge ACLK) begin
      if (push) mem[wr_ptr] <= push_p;
   end

   // A credit comes back on pop, or when the multiplier failed to return a product.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         credit <= CW'(FIFO_DEPTH);
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count  <= count + CW'(push) - CW'(pop);
         credit <= credit + CW'(pop) + CW'(drop) - CW'(grant);
         assert (!(push && full));
         assert (credit <= CW'(FIFO_DEPTH));
      end
   end
endmodule

module cmult_share_sched #(
   parameter int N          = 4,
   parameter int DW         = 16,
   parameter int PW         = 33,
   parameter int MULT_LAT   = 6,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [N-1:0]            s_valid,
   output logic [N-1:0]            s_ready,
   input  logic [N-1:0][2*DW-1:0]  s_a,
   input  logic [N-1:0][2*DW-1:0]  s_b,
   output logic                    m_valid,
   output logic [2*DW-1:0]         m_a,
   output logic [2*DW-1:0]         m_b,
   input  logic                    mult_valid,
   input  logic [2*PW-1:0]         mult_p,
   output logic [N-1:0]            r_valid,
   input  logic [N-1:0]            r_ready,
   output logic [N-1:0][2*PW-1:0]  r_p,
   output logic                    busy,
   output logic                    err
);
   localparam int IW = $clog2(N);

   logic [N-1:0]                credit_ok, elig, grant, push, drop;
   logic [IW-1:0]               last_grant, grant_id, cand;
   logic                        grant_any;
   // Stage 0 is the issue register itself; stage MULT_LAT lines up with mult_valid.
   logic [MULT_LAT:0]           vld_pipe;
   logic [MULT_LAT:0][IW-1:0]   id_pipe;
   logic                        ret_vld;
   logic [IW-1:0]               ret_id;

   assign elig    = s_valid & credit_ok;
   assign s_ready = grant;
   assign m_valid = vld_pipe[0];
   assign ret_vld = vld_pipe[MULT_LAT];
   assign ret_id  = id_pipe[MULT_LAT];
   assign busy    = (|vld_pipe) | (|r_valid);

   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_id  = '0;
      cand      = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(last_grant) + k) % N);
         if (!grant_any && elig[cand]) begin
            grant_any = 1'b1;
            grant_id  = cand;
         end
      end
      if (grant_any) grant[grant_id] = 1'b1;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         vld_pipe   <= '0;
         id_pipe    <= '0;
         m_a        <= '0;
         m_b        <= '0;
         last_grant <= IW'(N - 1);
         err        <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[MULT_LAT-1:0], grant_any};
         id_pipe  <= {id_pipe[MULT_LAT-1:0], grant_id};
         if (grant_any) begin
            m_a        <= s_a[grant_id];
            m_b        <= s_b[grant_id];
            last_grant <= grant_id;
         end
         if (mult_valid != ret_vld) err <= 1'b1;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      assign push[i] = mult_valid & ret_vld & (ret_id == IW'(i));
      assign drop[i] = ~mult_valid & ret_vld & (ret_id == IW'(i));

      cmult_share_lane #(.PW(PW), .FIFO_DEPTH(FIFO_DEPTH)) u_lane (
         .ACLK      (ACLK),
         .ARESET    (ARESET),
         .grant     (grant[i]),
         .push      (push[i]),
         .push_p    (mult_p),
         .drop      (drop[i]),
         .r_ready   (r_ready[i]),
         .credit_ok (credit_ok[i]),
         .r_valid   (r_valid[i]),
         .r_p       (r_p[i])
      );
   end
endmodule

// File: tb/tb_cmult_share_sched.sv
// Directed bench for cmult_share_sched with a latency-6 complex multiplier model.
// Requester i, k-th operand: a=(3+k)+j(4+i), b=1-2j, so product = (11+k+2i) + j(-2+i-2k).

module tb_cmult_share_sched;
   localparam int N = 4, DW = 16, PW = 33, L = 6, D = 8;

   logic                   ACLK = 1'b0;
   logic                   ARESET;
   logic [N-1:0]           s_valid, s_ready, r_valid, r_ready;
   logic [N-1:0][2*DW-1:0] s_a, s_b;
   logic                   m_valid, mult_valid, busy, err;
   logic [2*DW-1:0]        m_a, m_b;
   logic [2*PW-1:0]        mult_p;
   logic [N-1:0][2*PW-1:0] r_p;

   logic                   drop_now, spur_now;
   logic [L:1]             mv;
   logic [L:1][2*PW-1:0]   mp;
   int src_seq[N], exp_seq[N], acc[N], rcv[N], skip[N];
   logic [N-1:0]           hs;
   int glog[1024];
   int glen = 0;
   int nvec = 0, nerr = 0;

   always #5 ACLK = ~ACLK;

   cmult_share_sched #(.N(N), .DW(DW), .PW(PW), .MULT_LAT(L), .FIFO_DEPTH(D)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
      .m_valid(m_valid), .m_a(m_a), .m_b(m_b), .mult_valid(mult_valid), .mult_p(mult_p),
      .r_valid(r_valid), .r_ready(r_ready), .r_p(r_p), .busy(busy), .err(err)
   );

   function automatic logic [2*PW-1:0] cmul(input logic [2*DW-1:0] a, input logic [2*DW-1:0] b);
      logic signed [PW-1:0] xr, xi, yr, yi, re, im;
      xr = $signed(a[DW-1:0]);  xi = $signed(a[2*DW-1:DW]);
      yr = $signed(b[DW-1:0]);  yi = $signed(b[2*DW-1:DW]);
      re = xr * yr - xi * yi;
      im = xr * yi + xi * yr;
      return {im, re};
   endfunction

   function automatic logic [2*PW-1:0] expp(input int i, input int k);
      logic signed [PW-1:0] re, im;
      re = 11 + k + 2 * i;
      im = -2 + i - 2 * k;
      return {im, re};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge ACLK); #1;
   endtask

   task automatic neg();
      @(negedge ACLK);
   endtask

   task automatic drain();
      int n = 0;
      while (busy !== 1'b0 && n < 100) begin tick(); n++; end
      chk("drain_busy", busy, 0);
   endtask

   always_comb begin
      s_a = '0;
      s_b = '0;
      for (int i = 0; i < N; i++) begin
         s_a[i] = {16'(4 + i), 16'(3 + src_seq[i])};
         s_b[i] = {16'hFFFE, 16'h0001};
      end
   end

   // Multiplier model shares the reset so its pipeline is flushed with the scheduler's.
   always @(posedge ACLK) begin
      if (ARESET) mv <= '0;
      else        mv <= {mv[L-1:1], m_valid};
      mp <= {mp[L-1:1], cmul(m_a, m_b)};
   end
   assign mult_valid = (mv[L] & ~drop_now) | spur_now;
   assign mult_p     = mp[L];

   always @(posedge ACLK) begin
      for (int i = 0; i < N; i++)
         src_seq[i] <= ARESET ? 0 : src_seq[i] + int'(hs[i]);
   end

   always @(negedge ACLK) begin
      if (ARESET) begin
         hs = '0;
         for (int i = 0; i < N; i++) begin exp_seq[i] = 0; acc[i] = 0; rcv[i] = 0; end
      end else begin
         hs = s_valid & s_ready;
         chk("ready_onehot0", $onehot0(s_ready), 1);
         for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
               acc[i]++;
               glog[glen % 1024] = i;
               glen++;
            end
            if (r_valid[i] && r_ready[i]) begin
               chk($sformatf("result_r%0d_k%0d", i, exp_seq[i]), r_p[i], expp(i, exp_seq[i] + skip[i]));
               exp_seq[i]++;
               rcv[i]++;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int lat, base, ok, a0, a1, a3, r3;
      logic mv_ok;
      ARESET = 1'b1; s_valid = '0; r_ready = '0; drop_now = 1'b0; spur_now = 1'b0;
      for (int i = 0; i < N; i++) skip[i] = 0;
      tick(); tick();
      ARESET = 1'b0;
      neg();
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_ab", {m_a, m_b}, 0);
      chk("rst_r_valid", r_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);

      // single request, latency and value
      tick();
      s_valid = 4'b0001;
      neg();
      chk("t1_s_ready", s_ready, 4'b0001);
      chk("t1_m_valid_pre", m_valid, 0);
      tick();
      s_valid = '0;
      neg();
      chk("t1_m_valid", m_valid, 1);
      chk("t1_m_a", m_a, {16'h0004, 16'h0003});
      chk("t1_m_b", m_b, {16'hFFFE, 16'h0001});
      chk("t1_busy", busy, 1);
      lat = 1;
      while (r_valid[0] !== 1'b1 && lat < 20) begin tick(); lat++; end
      chk("t1_latency", lat, 8);
      chk("t1_r_p", r_p[0], {-33'sd2, 33'sd11});
      r_ready = 4'b0001;
      tick();
      r_ready = '0;
      neg();
      chk("t1_r_valid_after_pop", r_valid, 0);
      chk("t1_busy_after_pop", busy, 0);

      // saturated round robin
      tick();
      ARESET = 1'b1; tick(); tick(); ARESET = 1'b0;
      base = glen;
      s_valid = 4'b1111; r_ready = 4'b1111; mv_ok = 1'b1;
      for (int k = 0; k < 40; k++) begin
         neg();
         if (k > 0 && m_valid !== 1'b1) mv_ok = 1'b0;
         tick();
      end
      s_valid = '0;
      chk("t2_m_valid_streak", mv_ok, 1);
      drain();
      chk("t2_grants", glen - base, 40);
      ok = 1;
      for (int k = 0; k < 40; k++) if (glog[(base + k) % 1024] != k % 4) ok = 0;
      chk("t2_grant_order", ok, 1);
      chk("t2_acc", {acc[0], acc[1], acc[2], acc[3]}, {32'd10, 32'd10, 32'd10, 32'd10});
      chk("t2_rcv", {rcv[0], rcv[1], rcv[2], rcv[3]}, {32'd10, 32'd10, 32'd10, 32'd10});

      // backpressure on requester 2
      ARESET = 1'b1; tick(); tick(); ARESET = 1'b0;
      s_valid = 4'b1111; r_ready = 4'b1011;
      repeat (40) tick();
      chk("t3_acc2_capped", acc[2], 8);
      chk("t3_r_valid2", r_valid[2], 1);
      a0 = acc[0]; a1 = acc[1]; a3 = acc[3];
      neg();
      chk("t3_s_ready2", s_ready[2], 0);
      tick();
      repeat (11) tick();
      chk("t3_third_rate", {acc[0] - a0, acc[1] - a1, acc[3] - a3}, {32'd4, 32'd4, 32'd4});
      chk("t3_acc2_still", acc[2], 8);
      r_ready = 4'b1111;
      repeat (30) tick();
      chk("t3_req2_resumed", acc[2] > 8, 1);
      s_valid = '0;
      drain();
      chk("t3_all_returned", {acc[0] - rcv[0], acc[1] - rcv[1], acc[2] - rcv[2], acc[3] - rcv[3]}, 0);

      // credit boundary on requester 1
      a1 = acc[1];
      s_valid = 4'b0010; r_ready = '0;
      repeat (30) tick();
      chk("t4_fill", acc[1] - a1, 8);
      neg();
      chk("t4_full_no_ready", s_ready, 0);
      tick();
      r_ready = 4'b0010;
      neg();
      chk("t4_pop_cycle_no_grant", s_ready, 0);
      tick();
      r_ready = '0;
      neg();
      chk("t4_grant_after_pop", s_ready, 4'b0010);
      tick();
      neg();
      chk("t4_credit_zero_again", s_ready, 0);
      tick();
      s_valid = '0; r_ready = 4'b1111;
      drain();
      chk("t4_total", {acc[1] - a1, acc[1] - rcv[1]}, {32'd9, 32'd0});

      // dropped product
      s_valid = 4'b1000; r_ready = '0;
      neg();
      chk("t5_s_ready", s_ready, 4'b1000);
      tick();
      s_valid = '0;
      repeat (6) tick();
      drop_now = 1'b1;
      tick();
      drop_now = 1'b0;
      neg();
      chk("t5_err", err, 1);
      chk("t5_no_result", r_valid, 0);
      chk("t5_busy", busy, 0);
      tick();
      skip[3] = 1;
      a3 = acc[3]; r3 = rcv[3];
      s_valid = 4'b1000;
      repeat (25) tick();
      chk("t5_credit_restored", acc[3] - a3, 8);
      s_valid = '0; r_ready = 4'b1000;
      drain();
      chk("t5_after_drop_rcv", rcv[3] - r3, 8);

      // reset mid-burst
      s_valid = 4'b1111; r_ready = '0;
      repeat (10) tick();
      chk("t7_pre_busy", busy, 1);
      chk("t7_pre_fifo", |r_valid, 1);
      ARESET = 1'b1;
      for (int i = 0; i < N; i++) skip[i] = 0;
      tick(); tick();
      ARESET = 1'b0;
      neg();
      chk("t7_m_valid", m_valid, 0);
      chk("t7_m_ab", {m_a, m_b}, 0);
      chk("t7_r_valid", r_valid, 0);
      chk("t7_busy", busy, 0);
      chk("t7_err", err, 0);
      chk("t7_first_grant", s_ready, 4'b0001);
      tick();
      s_valid = '0; r_ready = 4'b1111;
      drain();
      chk("t7_post_counts", {acc[0], rcv[0], acc[1]}, {32'd1, 32'd1, 32'd0});
      chk("t7_no_err", err, 0);

      // spurious product
      spur_now = 1'b1;
      tick();
      spur_now = 1'b0;
      neg();
      chk("t6_err", err, 1);
      chk("t6_no_write", r_valid, 0);
      chk("t6_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
